// File: rtl/acc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : acc_seq_pkg                                                  |
// | Description : Layer codes and the passes-per-output table shared by the    |
// |               accumulator sequencer and the accumulator array top.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package acc_seq_pkg;

  typedef logic [2:0] layer_code_t;

  // Layer codes as carried on i_layer_state / o_acc_layer.
  localparam layer_code_t c_layer_idle = 3'b000;
  localparam layer_code_t c_layer_c1   = 3'b001;
  localparam layer_code_t c_layer_s2   = 3'b010;
  localparam layer_code_t c_layer_c3   = 3'b011;
  localparam layer_code_t c_layer_s4   = 3'b100;
  localparam layer_code_t c_layer_c5   = 3'b101;

  // Pass counter is 5 bits: the largest layer needs 16 passes per output.
  localparam int          c_pass_bw    = 5;
  localparam logic [4:0]  c_pass_max   = 5'd16;

  // A start is only meaningful for one of the five real layers.
  function automatic logic layer_is_valid(input layer_code_t code);
    return (code >= c_layer_c1) && (code <= c_layer_c5);
  endfunction

  // Multiplier beats that must be summed into one output of a layer.
  // Subsampling layers and the first convolution need a single beat;
  // C3 folds 6 input maps and C5 folds 16.
  function automatic logic [4:0] layer_passes(input layer_code_t code);
    logic [4:0] passes;
    case (code)
      c_layer_c3: passes = 5'd6;
      c_layer_c5: passes = c_pass_max;
      default:    passes = 5'd1;
    endcase
    return passes;
  endfunction

endpackage : acc_seq_pkg
`default_nettype wire

// File: rtl/acc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : acc_seq                                                      |
// | Description : Accumulator sequencer. For each output of a layer it clears  |
// |               the accumulators, accepts P multiplier beats, waits for the  |
// |               accumulator pipeline to settle, then presents the result     |
// |               with a valid/ready handshake. Pulses o_done at layer end.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk           in   clock, all logic on rising edge                       |
// |   rst_n         in   asynchronous active-low reset                         |
// |   i_start       in   start pulse, honoured only when idle                  |
// |   i_layer_state in   [2:0] layer code, sampled with i_start                |
// |   i_num_out     in   [CNT_BW-1:0] outputs for the layer, sampled w/ start  |
// |   i_mul_valid   in   multiplier-array beat present                         |
// |   o_mul_ready   out  beat accepted this cycle (decoded from state)         |
// |   o_acc_layer   out  [2:0] latched layer code to the accumulator array    |
// |   o_acc_clear   out  one-cycle accumulator clear                           |
// |   o_out_valid   out  accumulated result valid                              |
// |   i_out_ready   in   downstream accepts result                             |
// |   o_busy        out  high whenever not idle (decoded from state)           |
// |   o_done        out  one-cycle pulse after last result accepted            |
// +----------------------------------------------------------------------------+
module acc_seq
  import acc_seq_pkg::*;
#(
  parameter int ACC_LAT = 2,
  parameter int CNT_BW  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_layer_state,
  input  logic [CNT_BW-1:0] i_num_out,
  input  logic              i_mul_valid,
  output logic              o_mul_ready,
  output logic [2:0]        o_acc_layer,
  output logic              o_acc_clear,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_clear = 3'd1;
  localparam logic [2:0] c_st_accum = 3'd2;
  localparam logic [2:0] c_st_drain = 3'd3;
  localparam logic [2:0] c_st_out   = 3'd4;
  localparam logic [2:0] c_st_done  = 3'd5;

  // Drain counter runs 0..ACC_LAT-1. With ACC_LAT == 0 the drain state is
  // bypassed entirely and the counter is a harmless single bit.
  localparam int                  c_drain_w    = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'((ACC_LAT > 0) ? ACC_LAT - 1 : 0);
  localparam logic [c_drain_w-1:0] c_drain_one  = c_drain_w'(1);
  localparam logic [CNT_BW-1:0]    c_out_one    = CNT_BW'(1);
  localparam logic [4:0]           c_pass_one   = 5'd1;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]           r_state;
  logic [2:0]           w_next_state;

  layer_code_t          r_layer;
  logic [4:0]           r_passes;
  logic [CNT_BW-1:0]    r_num_out;
  logic [c_pass_bw-1:0] r_pass_cnt;
  logic [CNT_BW-1:0]    r_out_cnt;
  logic [c_drain_w-1:0] r_drain_cnt;

  logic                 r_acc_clear;
  logic                 r_out_valid;
  logic                 r_done;
  logic                 w_acc_clear_d;
  logic                 w_out_valid_d;
  logic                 w_done_d;

  logic                 w_start_ok;
  logic                 w_beat;
  logic                 w_last_beat;
  logic                 w_out_hs;
  logic                 w_last_out;
  logic [CNT_BW-1:0]    w_out_cnt_inc;
  logic [4:0]           w_pass_cnt_inc;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  assign w_start_ok     = (r_state == c_st_idle) && i_start &&
                          layer_is_valid(i_layer_state) && (i_num_out != '0);
  assign w_beat         = (r_state == c_st_accum) && i_mul_valid;
  assign w_pass_cnt_inc = r_pass_cnt + c_pass_one;
  // The pass counter never exceeds the latched pass count, so the compare
  // against count+1 cannot wrap even at 16 passes.
  assign w_last_beat    = w_beat && (w_pass_cnt_inc == r_passes);
  assign w_out_hs       = (r_state == c_st_out) && i_out_ready;
  assign w_out_cnt_inc  = r_out_cnt + c_out_one;
  assign w_last_out     = (w_out_cnt_inc == r_num_out);

  // --------------------------------------------------------------------------
  // State register (plus registered outputs, which follow the next state so
  // they are aligned with the state they describe)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_acc_clear <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_acc_clear <= w_acc_clear_d;
      r_out_valid <= w_out_valid_d;
      r_done      <= w_done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_start_ok) begin
          w_next_state = c_st_clear;
        end
      end
      c_st_clear: begin
        w_next_state = c_st_accum;
      end
      c_st_accum: begin
        if (w_last_beat) begin
          if (ACC_LAT == 0) begin
            w_next_state = c_st_out;
          end else begin
            w_next_state = c_st_drain;
          end
        end
      end
      c_st_drain: begin
        if (r_drain_cnt == c_drain_last) begin
          w_next_state = c_st_out;
        end
      end
      c_st_out: begin
        if (i_out_ready) begin
          w_next_state = w_last_out ? c_st_done : c_st_clear;
        end
      end
      c_st_done: begin
        w_next_state = c_st_idle;
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    o_mul_ready   = (r_state == c_st_accum);
    o_busy        = (r_state != c_st_idle);
    w_acc_clear_d = (w_next_state == c_st_clear);
    w_out_valid_d = (w_next_state == c_st_out);
    w_done_d      = (w_next_state == c_st_done);
  end

  assign o_acc_clear = r_acc_clear;
  assign o_out_valid = r_out_valid;
  assign o_done      = r_done;
  assign o_acc_layer = r_layer;

  // --------------------------------------------------------------------------
  // Layer context and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer   <= c_layer_idle;
      r_passes  <= '0;
      r_num_out <= '0;
    end else if (w_start_ok) begin
      r_layer   <= i_layer_state;
      r_passes  <= layer_passes(i_layer_state);
      r_num_out <= i_num_out;
    end else if (r_state == c_st_done) begin
      // DONE always exits on the next edge, so the code drops with it.
      r_layer   <= c_layer_idle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= '0;
    end else if (r_state == c_st_clear) begin
      r_pass_cnt <= '0;
    end else if (w_beat) begin
      r_pass_cnt <= w_pass_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
    end else if (w_start_ok) begin
      r_out_cnt <= '0;
    end else if (w_out_hs) begin
      r_out_cnt <= w_out_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt <= '0;
    end else if (r_state == c_st_drain) begin
      r_drain_cnt <= r_drain_cnt + c_drain_one;
    end else begin
      r_drain_cnt <= '0;
    end
  end

endmodule : acc_seq
`default_nettype wire

// File: tb/tb_acc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_acc_seq                                                   |
// | Description : Self-checking bench for acc_seq. Each layer is played out    |
// |               as a sequence of phases derived from the layer rules         |
// |               (clear, P accepted beats, ACC_LAT drain, held result, done)  |
// |               with random valid/ready/start noise.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_acc_seq;

  localparam int ACC_LAT = 2;
  localparam int CNT_BW  = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [2:0]        i_layer_state = 3'd0;
  logic [CNT_BW-1:0] i_num_out = '0;
  logic              i_mul_valid = 1'b0;
  logic              o_mul_ready;
  logic [2:0]        o_acc_layer;
  logic              o_acc_clear;
  logic              o_out_valid;
  logic              i_out_ready = 1'b0;
  logic              o_busy;
  logic              o_done;

  int n_checks = 0;
  int n_fail   = 0;

  acc_seq #(.ACC_LAT(ACC_LAT), .CNT_BW(CNT_BW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_layer_state (i_layer_state),
    .i_num_out     (i_num_out),
    .i_mul_valid   (i_mul_valid),
    .o_mul_ready   (o_mul_ready),
    .o_acc_layer   (o_acc_layer),
    .o_acc_clear   (o_acc_clear),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Passes per output, straight from the layer table.
  function automatic int passes_of(input int code);
    case (code)
      3:       return 6;
      5:       return 16;
      default: return 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start pulses and layer/count changes while busy must have no effect.
  task automatic noise();
    i_start       = ($urandom_range(0, 3) == 0);
    i_layer_state = 3'($urandom_range(0, 7));
    i_num_out     = CNT_BW'($urandom_range(0, 1023));
  endtask

  task automatic quiet();
    i_start       = 1'b0;
    i_layer_state = 3'd0;
    i_num_out     = '0;
    i_mul_valid   = 1'b0;
    i_out_ready   = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(o_busy),      0);
    chk({tag, "_layer"}, 32'(o_acc_layer), 0);
    chk({tag, "_clear"}, 32'(o_acc_clear), 0);
    chk({tag, "_valid"}, 32'(o_out_valid), 0);
    chk({tag, "_ready"}, 32'(o_mul_ready), 0);
    chk({tag, "_done"},  32'(o_done),      0);
  endtask

  // vmode: 0 valid always high, 1 valid toggling starting high, 2 random.
  // stall: >=0 ready held low that many OUT cycles, <0 random ready.
  task automatic run_layer(input int code, input int n, input int vmode, input int stall);
    int   p;
    int   beats;
    int   cyc;
    int   w;
    logic v;
    logic r;
    p = passes_of(code);
    i_start       = 1'b1;
    i_layer_state = 3'(code);
    i_num_out     = CNT_BW'(n);
    i_mul_valid   = 1'($urandom_range(0, 1));
    i_out_ready   = 1'($urandom_range(0, 1));
    tick();
    for (int o = 0; o < n; o++) begin
      chk("clear_pulse", 32'(o_acc_clear), 1);
      chk("clear_layer", 32'(o_acc_layer), 32'(code));
      chk("clear_ready", 32'(o_mul_ready), 0);
      chk("clear_valid", 32'(o_out_valid), 0);
      chk("clear_busy",  32'(o_busy),      1);
      noise();
      i_mul_valid = 1'($urandom_range(0, 1));
      i_out_ready = 1'($urandom_range(0, 1));
      tick();
      beats = 0;
      cyc   = 0;
      while (beats < p && cyc < 100) begin
        chk("accum_ready", 32'(o_mul_ready), 1);
        chk("accum_valid", 32'(o_out_valid), 0);
        chk("accum_clear", 32'(o_acc_clear), 0);
        chk("accum_layer", 32'(o_acc_layer), 32'(code));
        case (vmode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        i_mul_valid = v;
        i_out_ready = 1'($urandom_range(0, 1));
        noise();
        tick();
        cyc++;
        if (v) beats++;
      end
      if (beats < p) begin
        chk("beat_timeout", 32'(beats), 32'(p));
        quiet();
        return;
      end
      if (vmode == 0) chk("accum_cycles", 32'(cyc), 32'(p));
      if (vmode == 1) chk("accum_cycles_toggle", 32'(cyc), 32'(2 * p - 1));
      for (int d = 0; d < ACC_LAT; d++) begin
        chk("drain_ready", 32'(o_mul_ready), 0);
        chk("drain_valid", 32'(o_out_valid), 0);
        chk("drain_busy",  32'(o_busy),      1);
        i_mul_valid = 1'($urandom_range(0, 1));
        i_out_ready = 1'($urandom_range(0, 1));
        noise();
        tick();
      end
      w = 0;
      forever begin
        chk("out_valid", 32'(o_out_valid), 1);
        chk("out_ready", 32'(o_mul_ready), 0);
        chk("out_layer", 32'(o_acc_layer), 32'(code));
        if (stall < 0) r = 1'($urandom_range(0, 1));
        else           r = (w >= stall);
        i_out_ready = r;
        i_mul_valid = 1'($urandom_range(0, 1));
        noise();
        tick();
        if (r) break;
        w++;
        if (w > 200) begin
          chk("out_timeout", 32'(w), 0);
          quiet();
          return;
        end
      end
    end
    chk("done_pulse", 32'(o_done),      1);
    chk("done_valid", 32'(o_out_valid), 0);
    chk("done_busy",  32'(o_busy),      1);
    chk("done_clear", 32'(o_acc_clear), 0);
    chk("done_layer", 32'(o_acc_layer), 32'(code));
    noise();
    tick();
    chk_idle("post_done");
    quiet();
  endtask

  initial begin
    // Reset state, observed while reset is held.
    #2;
    chk_idle("reset");
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset_held");
    rst_n = 1'b1;
    tick();
    chk_idle("after_release");

    // Directed layers.
    run_layer(1, 3, 0, 0);    // C1, three outputs back to back
    run_layer(3, 1, 0, 0);    // C3, six beats
    run_layer(5, 1, 1, 0);    // C5, toggling valid
    run_layer(2, 2, 0, 10);   // S2, downstream stalls 10 cycles
    run_layer(4, 2, 2, -1);   // S4, random handshakes

    // Ignored starts: bad codes and zero output count.
    for (int k = 0; k < 4; k++) begin
      i_start       = 1'b1;
      i_layer_state = (k == 0) ? 3'd6 : (k == 1) ? 3'd7 : (k == 2) ? 3'd0 : 3'd1;
      i_num_out     = (k == 3) ? '0 : CNT_BW'(3);
      i_mul_valid   = 1'b1;
      i_out_ready   = 1'b1;
      tick();
      quiet();
      chk_idle("bad_start");
      tick();
      chk("bad_start_busy2", 32'(o_busy), 0);
    end

    // Random layers.
    for (int k = 0; k < 8; k++) begin
      run_layer($urandom_range(1, 5), $urandom_range(1, 4),
                $urandom_range(0, 2), $urandom_range(0, 1) ? -1 : $urandom_range(0, 4));
    end

    // Reset during C5 accumulation after seven beats.
    i_start       = 1'b1;
    i_layer_state = 3'd5;
    i_num_out     = CNT_BW'(2);
    tick();
    chk("rst_seq_clear", 32'(o_acc_clear), 1);
    quiet();
    i_mul_valid = 1'b1;
    tick();
    for (int b = 0; b < 7; b++) begin
      chk("rst_seq_ready", 32'(o_mul_ready), 1);
      tick();
    end
    chk("rst_seq_still_accum", 32'(o_mul_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    i_start       = 1'b1;
    i_layer_state = 3'd1;
    i_num_out     = CNT_BW'(1);
    tick();
    chk_idle("reset_hold_edge");
    quiet();
    #2;
    rst_n = 1'b1;
    tick();
    chk_idle("reset_no_done");
    run_layer(1, 1, 0, 0);
    run_layer(3, 2, 2, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_acc_seq
`default_nettype wire
